// File: rtl/ovl_frame_pkg.sv
// Shared encodings and sizing helpers for the multi-channel frame checker.
package ovl_frame_pkg;

  localparam int OVL_FRAME_IGNORE = 0;
  localparam int OVL_FRAME_RESET  = 1;
  localparam int OVL_FRAME_ERROR  = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    WINDOW = 1'b1
  } frame_state_e;

  // Counter must hold the larger bound; never narrower than one bit.
  function automatic int frame_cnt_w(input int min_cks, input int max_cks);
    int m;
    m = (min_cks > max_cks) ? min_cks : max_cks;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ovl_frame_chan.sv
// One frame-checker channel: start edge detect, window state/counter and
// registered violation pulses.
module ovl_frame_chan
  import ovl_frame_pkg::*;
#(
  parameter int MIN_CKS             = 1,
  parameter int MAX_CKS             = 2,
  parameter int ACTION_ON_NEW_START = 0,
  parameter int CNT_W               = frame_cnt_w(MIN_CKS, MAX_CKS)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic cfg_ok,
  input  logic start_event,
  input  logic test_expr,
  output logic win,
  output logic fire_min,
  output logic fire_max,
  output logic fire_new_start,
  output logic start_accept
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CKS);
  localparam bit ACT_RESET = (ACTION_ON_NEW_START == OVL_FRAME_RESET);
  localparam bit ACT_ERROR = (ACTION_ON_NEW_START == OVL_FRAME_ERROR);
  localparam bit NO_WINDOW = (MIN_CKS == 0) && (MAX_CKS == 0);

  frame_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             r_start_q, r_start_d;
  logic             fire_min_q, fire_min_d;
  logic             fire_max_q, fire_max_d;
  logic             fire_new_start_q, fire_new_start_d;
  logic             rise;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    r_start_d        = start_event;
    fire_min_d       = 1'b0;
    fire_max_d       = 1'b0;
    fire_new_start_d = 1'b0;
    start_accept     = 1'b0;
    rise             = start_event & ~r_start_q;

    if (!enable || !cfg_ok) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            start_accept = 1'b1;
            if (test_expr) begin
              fire_min_d = (MIN_CKS > 0);
            end else if (!NO_WINDOW) begin
              state_d = WINDOW;
              cnt_d   = ONE;
            end
          end
        end
        WINDOW: begin
          // Completion and timeout take precedence over a re-start.
          if (test_expr) begin
            fire_min_d       = (int'(cnt_q) < MIN_CKS);
            fire_new_start_d = rise && ACT_ERROR;
            state_d          = IDLE;
            cnt_d            = '0;
          end else if ((MAX_CKS > 0) && (cnt_q == MAX_C)) begin
            fire_max_d       = 1'b1;
            fire_new_start_d = rise && ACT_ERROR;
            state_d          = IDLE;
            cnt_d            = '0;
          end else if ((MAX_CKS == 0) && (int'(cnt_q) >= MIN_CKS)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (rise && ACT_RESET) begin
            cnt_d        = ONE;
            start_accept = 1'b1;
          end else begin
            cnt_d            = cnt_q + ONE;
            fire_new_start_d = rise && ACT_ERROR;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      r_start_q        <= 1'b0;
      fire_min_q       <= 1'b0;
      fire_max_q       <= 1'b0;
      fire_new_start_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      r_start_q        <= r_start_d;
      fire_min_q       <= fire_min_d;
      fire_max_q       <= fire_max_d;
      fire_new_start_q <= fire_new_start_d;
    end
  end

  assign win            = (state_q == WINDOW);
  assign fire_min       = fire_min_q;
  assign fire_max       = fire_max_q;
  assign fire_new_start = fire_new_start_q;

endmodule

// File: rtl/ovl_frame_multi.sv
// Multi-channel frame checker: NUM_CH independent channels plus a shared
// saturating start counter and static configuration check.
module ovl_frame_multi
  import ovl_frame_pkg::*;
#(
  parameter int NUM_CH              = 4,
  parameter int MIN_CKS             = 1,
  parameter int MAX_CKS             = 2,
  parameter int ACTION_ON_NEW_START = 0,
  parameter int COV_W               = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [NUM_CH-1:0] start_event,
  input  logic [NUM_CH-1:0] test_expr,
  output logic [NUM_CH-1:0] win,
  output logic [NUM_CH-1:0] fire_min,
  output logic [NUM_CH-1:0] fire_max,
  output logic [NUM_CH-1:0] fire_new_start,
  output logic [COV_W-1:0]  cov_starts,
  output logic              cfg_err
);

  localparam int CNT_W = frame_cnt_w(MIN_CKS, MAX_CKS);
  localparam bit CFG_BAD = ((MAX_CKS != 0) && (MAX_CKS < MIN_CKS)) ||
                           (ACTION_ON_NEW_START > OVL_FRAME_ERROR);
  localparam int PC_W  = $clog2(NUM_CH + 1);
  localparam int SUM_W = COV_W + PC_W;
  localparam logic [SUM_W-1:0] COV_MAX = {{PC_W{1'b0}}, {COV_W{1'b1}}};

  logic [NUM_CH-1:0] start_accept;
  logic [PC_W-1:0]   pop;
  logic [SUM_W-1:0]  sum;
  logic [COV_W-1:0]  cov_q, cov_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ovl_frame_chan #(
      .MIN_CKS            (MIN_CKS),
      .MAX_CKS            (MAX_CKS),
      .ACTION_ON_NEW_START(ACTION_ON_NEW_START),
      .CNT_W              (CNT_W)
    ) u_chan (
      .clk           (clk),
      .reset_n       (reset_n),
      .enable        (enable),
      .cfg_ok        (!CFG_BAD),
      .start_event   (start_event[i]),
      .test_expr     (test_expr[i]),
      .win           (win[i]),
      .fire_min      (fire_min[i]),
      .fire_max      (fire_max[i]),
      .fire_new_start(fire_new_start[i]),
      .start_accept  (start_accept[i])
    );
  end

  // Several channels may start together; add them all, then clamp.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pop = pop + PC_W'(start_accept[i]);
    end
    sum   = SUM_W'(cov_q) + SUM_W'(pop);
    cov_d = (sum > COV_MAX) ? {COV_W{1'b1}} : sum[COV_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cov_q <= '0;
    end else begin
      cov_q <= cov_d;
    end
  end

  assign cov_starts = cov_q;
  assign cfg_err    = CFG_BAD;

endmodule

// File: tb/tb_ovl_frame_multi.sv
// Bench for ovl_frame_multi: four legal configurations and one illegal one
// share stimulus and are compared each cycle against a behavioural model.
module tb_ovl_frame_multi;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] st;
  logic [3:0] te;

  logic [4:0][3:0] win_o, fmin_o, fmax_o, fns_o;
  logic [2:0][15:0] cov_o;
  logic [1:0]       cov_sat;
  logic [15:0]      cov_bad;
  logic [4:0]       cfg_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Model configurations: ignore, reset, error, ignore with 2-bit counter.
  int cmin[4] = '{2, 2, 2, 2};
  int cmax[4] = '{4, 4, 4, 4};
  int cact[4] = '{0, 1, 2, 0};
  int csat[4] = '{65535, 65535, 65535, 3};

  bit         open_m[4][4];
  int         age_m[4][4];
  logic [3:0] prev_m;
  logic [3:0] ew[4], efmin[4], efmax[4], efns[4];
  int         ecov[4];

  ovl_frame_multi #(.NUM_CH(4), .MIN_CKS(2), .MAX_CKS(4), .ACTION_ON_NEW_START(0), .COV_W(16)) u_ign (
    .clk(clk), .reset_n(rst_n), .enable(en), .start_event(st), .test_expr(te),
    .win(win_o[0]), .fire_min(fmin_o[0]), .fire_max(fmax_o[0]), .fire_new_start(fns_o[0]),
    .cov_starts(cov_o[0]), .cfg_err(cfg_o[0]));
  ovl_frame_multi #(.NUM_CH(4), .MIN_CKS(2), .MAX_CKS(4), .ACTION_ON_NEW_START(1), .COV_W(16)) u_rst (
    .clk(clk), .reset_n(rst_n), .enable(en), .start_event(st), .test_expr(te),
    .win(win_o[1]), .fire_min(fmin_o[1]), .fire_max(fmax_o[1]), .fire_new_start(fns_o[1]),
    .cov_starts(cov_o[1]), .cfg_err(cfg_o[1]));
  ovl_frame_multi #(.NUM_CH(4), .MIN_CKS(2), .MAX_CKS(4), .ACTION_ON_NEW_START(2), .COV_W(16)) u_err (
    .clk(clk), .reset_n(rst_n), .enable(en), .start_event(st), .test_expr(te),
    .win(win_o[2]), .fire_min(fmin_o[2]), .fire_max(fmax_o[2]), .fire_new_start(fns_o[2]),
    .cov_starts(cov_o[2]), .cfg_err(cfg_o[2]));
  ovl_frame_multi #(.NUM_CH(4), .MIN_CKS(2), .MAX_CKS(4), .ACTION_ON_NEW_START(0), .COV_W(2)) u_sat (
    .clk(clk), .reset_n(rst_n), .enable(en), .start_event(st), .test_expr(te),
    .win(win_o[3]), .fire_min(fmin_o[3]), .fire_max(fmax_o[3]), .fire_new_start(fns_o[3]),
    .cov_starts(cov_sat), .cfg_err(cfg_o[3]));
  ovl_frame_multi #(.NUM_CH(4), .MIN_CKS(5), .MAX_CKS(3), .ACTION_ON_NEW_START(0), .COV_W(16)) u_bad (
    .clk(clk), .reset_n(rst_n), .enable(en), .start_event(st), .test_expr(te),
    .win(win_o[4]), .fire_min(fmin_o[4]), .fire_max(fmax_o[4]), .fire_new_start(fns_o[4]),
    .cov_starts(cov_bad), .cfg_err(cfg_o[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        open_m[k][c] = 1'b0;
        age_m[k][c]  = 0;
      end
      ew[k] = '0; efmin[k] = '0; efmax[k] = '0; efns[k] = '0;
      ecov[k] = 0;
    end
    prev_m = '0;
  endtask

  // One clock edge of the specified channel behaviour, with integer ages.
  task automatic model_update();
    for (int k = 0; k < 4; k++) begin
      int acc;
      acc = 0;
      for (int c = 0; c < 4; c++) begin
        bit rise;
        rise = st[c] && !prev_m[c];
        efmin[k][c] = 1'b0;
        efmax[k][c] = 1'b0;
        efns[k][c]  = 1'b0;
        if (!en) begin
          open_m[k][c] = 1'b0;
          age_m[k][c]  = 0;
        end else if (!open_m[k][c]) begin
          if (rise) begin
            acc++;
            if (te[c]) efmin[k][c] = (cmin[k] > 0);
            else if (cmin[k] > 0 || cmax[k] > 0) begin
              open_m[k][c] = 1'b1;
              age_m[k][c]  = 1;
            end
          end
        end else if (te[c]) begin
          efmin[k][c]  = (age_m[k][c] < cmin[k]);
          efns[k][c]   = rise && (cact[k] == 2);
          open_m[k][c] = 1'b0;
        end else if (cmax[k] > 0 && age_m[k][c] == cmax[k]) begin
          efmax[k][c]  = 1'b1;
          efns[k][c]   = rise && (cact[k] == 2);
          open_m[k][c] = 1'b0;
        end else if (cmax[k] == 0 && age_m[k][c] >= cmin[k]) begin
          open_m[k][c] = 1'b0;
        end else if (rise && cact[k] == 1) begin
          age_m[k][c] = 1;
          acc++;
        end else begin
          age_m[k][c]++;
          efns[k][c] = rise && (cact[k] == 2);
        end
        ew[k][c] = open_m[k][c];
      end
      ecov[k] = (ecov[k] + acc > csat[k]) ? csat[k] : ecov[k] + acc;
    end
    prev_m = st;
  endtask

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("win[%0d]", k), 32'(win_o[k]), 32'(ew[k]));
      chk($sformatf("fire_min[%0d]", k), 32'(fmin_o[k]), 32'(efmin[k]));
      chk($sformatf("fire_max[%0d]", k), 32'(fmax_o[k]), 32'(efmax[k]));
      chk($sformatf("fire_new_start[%0d]", k), 32'(fns_o[k]), 32'(efns[k]));
      chk($sformatf("cfg_err[%0d]", k), 32'(cfg_o[k]), 32'd0);
      if (k < 3) chk($sformatf("cov[%0d]", k), 32'(cov_o[k]), 32'(ecov[k]));
      else       chk("cov_sat", 32'(cov_sat), 32'(ecov[3]));
    end
    chk("bad_win", 32'(win_o[4]), 32'd0);
    chk("bad_fires", 32'(fmin_o[4] | fmax_o[4] | fns_o[4]), 32'd0);
    chk("bad_cov", 32'(cov_bad), 32'd0);
    chk("bad_cfg_err", 32'(cfg_o[4]), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; st = '0; te = '0;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    step(); step();

    // Clean frame on channel 0: completes at edge 3.
    st = 4'b0001; step();
    step(); step();
    chk("A_win_open", 32'(win_o[0][0]), 32'd1);
    te = 4'b0001; step();
    chk("A_win_closed", 32'(win_o[0][0]), 32'd0);
    chk("A_no_fire", 32'(fmin_o[0][0] | fmax_o[0][0]), 32'd0);
    chk("A_cov", 32'(cov_o[0]), 32'd1);
    st = '0; te = '0; step();

    // Early completion on channel 1, then completion on the rise edge.
    st = 4'b0010; step();
    te = 4'b0010; step();
    chk("B_fire_min", 32'(fmin_o[0][1]), 32'd1);
    step();
    chk("B_pulse_once", 32'(fmin_o[0][1]), 32'd0);
    st = '0; te = '0; step();
    st = 4'b0010; te = 4'b0010; step();
    chk("B_fire_min_imm", 32'(fmin_o[0][1]), 32'd1);
    st = '0; te = '0; step();

    // Timeout on channel 2 at edge 4.
    st = 4'b0100; step();
    step(); step(); step();
    chk("C_win_before", 32'(win_o[0][2]), 32'd1);
    step();
    chk("C_fire_max", 32'(fmax_o[0][2]), 32'd1);
    chk("C_win_drop", 32'(win_o[0][2]), 32'd0);
    st = '0; step(); step();

    // Re-rise at edge 2 on channel 3 under each action.
    st = 4'b1000; step();
    st = 4'b0000; step();
    st = 4'b1000; step();
    chk("D_err_new_start", 32'(fns_o[2][3]), 32'd1);
    chk("D_ign_no_new_start", 32'(fns_o[0][3]), 32'd0);
    step(); step();
    chk("D_ign_max_e4", 32'(fmax_o[0][3]), 32'd1);
    chk("D_err_max_e4", 32'(fmax_o[2][3]), 32'd1);
    chk("D_rst_no_max_e4", 32'(fmax_o[1][3]), 32'd0);
    step(); step();
    chk("D_rst_max_e6", 32'(fmax_o[1][3]), 32'd1);
    st = '0; step(); step();

    // All channels together, then async reset mid-window.
    st = 4'b1111; step();
    chk("E_cov_sat", 32'(cov_sat), 32'd3);
    step();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("E_win_cleared", 32'(win_o[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; st = '0;
    for (int i = 0; i < 6; i++) step();

    // Disable in the middle of a window.
    st = 4'b0001; step();
    en = 1'b0; step(); step();
    en = 1'b1; st = '0; step();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) st = st ^ 4'($urandom);
      te = 4'($urandom & $urandom & $urandom);
      en = ($urandom_range(0, 31) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ovl_frame_multi.md
# ovl_frame_multi

Parametrised multi-channel frame checker. It is the next generation of the single-channel frame assertion. Each of `NUM_CH` independent channels watches a `start_event` rising edge. It then requires `test_expr` to stay low for at least `MIN_CKS` cycles and to rise within `MAX_CKS` cycles. Violations are reported as registered per-channel fire pulses, together with a saturating start counter for coverage. The block sits beside the design under check and drives only checker outputs.

## Interface
Parameters:
- `NUM_CH`, 4: number of independent channels (1..32).
- `MIN_CKS`, 1: minimum cycles after start before `test_expr` may rise; 0 disables the minimum check.
- `MAX_CKS`, 2: maximum cycles after start by which `test_expr` must rise; 0 disables the maximum check.
- `ACTION_ON_NEW_START`, 0: 0 = ignore, 1 = reset window, 2 = error.
- `COV_W`, 16: width of the coverage counter.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `enable` input 1: global check enable; when low, channels are held in IDLE and fire outputs are 0.
- `start_event` input NUM_CH: per-channel start signal; its rising edge opens a window.
- `test_expr` input NUM_CH: per-channel completion signal.
- `win` output NUM_CH: channel is in WINDOW.
- `fire_min` output NUM_CH: `test_expr` rose before `MIN_CKS`.
- `fire_max` output NUM_CH: `MAX_CKS` elapsed without `test_expr`.
- `fire_new_start` output NUM_CH: rising start during an open window while in error mode.
- `cov_starts` output COV_W: saturating count of accepted starts, summed over all channels.
- `cfg_err` output 1: static high when `MAX_CKS != 0 && MAX_CKS < MIN_CKS` or `ACTION_ON_NEW_START > 2`. When it is high, all channels stay in IDLE.

## Operation
- Each channel has a registered `r_start` (reset 0). `rise = start_event & ~r_start`.
- Each channel has states IDLE and WINDOW, and an elapsed counter `cnt` of width `$clog2(max(MIN_CKS,MAX_CKS)+1)`.

In IDLE, on `rise`:
- If `test_expr`=1: the window completes immediately. `fire_min` fires if `MIN_CKS>0`. Stay in IDLE.
- Otherwise go to WINDOW with `cnt<=1`.
- In both cases `cov_starts` increments, saturating at all-ones.

In WINDOW, evaluate in this priority order:
1. `test_expr`=1: `fire_min` fires if `cnt<MIN_CKS`. Go to IDLE.
2. `MAX_CKS>0 && cnt==MAX_CKS`: `fire_max` fires. Go to IDLE.
3. `MAX_CKS==0 && cnt>=MIN_CKS`: go to IDLE silently.
4. `rise`, depending on action:
   - Ignore: `cnt++`.
   - Reset: `cnt<=1`, and `cov_starts` increments.
   - Error: `fire_new_start` fires and `cnt++`.
5. Otherwise: `cnt++`.

Additional rules:
- With error action, `rise` coincident with case 1 or 2 also fires `fire_new_start`. With the other actions such a `rise` is dropped.
- If several channels start in the same cycle, `cov_starts` adds their popcount, saturating.
- `enable` low: state goes to IDLE, `cnt` to 0, fires are 0. `r_start` keeps tracking its input.
- `MIN_CKS==0 && MAX_CKS==0`: the channel never enters WINDOW.

## Timing
- Reset values: all outputs 0 except `cfg_err`, which is constant. `r_start`, `cnt` and state are 0 / IDLE.
- A fire pulse is registered. It is high for exactly one cycle, in the cycle after the clock edge at which the violation was sampled.
- `win` goes high in the cycle after the rise is sampled and reflects the state register.
- Window length counts edges after the start: `test_expr` sampled at edge k after start sees `cnt==k`.
- Asserting `reset_n` mid-window clears everything immediately. No fire is produced for the aborted window.

## Structure
- Package `ovl_frame_pkg` holds:
  - the action encodings `OVL_FRAME_IGNORE`=0, `OVL_FRAME_RESET`=1, `OVL_FRAME_ERROR`=2;
  - the state enum `{IDLE, WINDOW}`;
  - the function `frame_cnt_w(min, max)`.
- Sub-module `ovl_frame_chan` implements one channel: state, counter, `r_start`, and the three fire flops. It outputs `start_accept`.
- The top level generates `NUM_CH` instances, plus the popcount/saturating `cov_starts` and the `cfg_err` logic.

## Test plan
Defaults for all scenarios: `NUM_CH`=4, `MIN_CKS`=2, `MAX_CKS`=4.
- Channel 0 rises at edge 0, `test_expr` high at edge 3 -> no fire, `win` high for 3 cycles, `cov_starts`=1.
- Channel 1 rises, `test_expr` high at edge 1 -> `fire_min[1]` one-cycle pulse after edge 1. `test_expr` high on the rise edge itself -> `fire_min[1]` after that edge.
- Channel 2 rises, `test_expr` stays low -> `fire_max[2]` after edge 4. `win` drops at the same time.
- Re-rise at edge 2 of an open window:
  - action reset -> window extends, and `fire_max` lands at edge 6;
  - action error -> `fire_new_start` pulse, and `fire_max` at edge 4;
  - action ignore -> no extra effect.
- All 4 channels rise together with `COV_W`=2 -> `cov_starts` saturates at 3. Pulling `reset_n` low mid-window -> outputs go to 0 asynchronously and no fire is produced.
- `MIN_CKS`=5, `MAX_CKS`=3 -> `cfg_err`=1 and no channel ever asserts `win`.
